// File: rtl/hamster_pop_ctrl_pkg.sv
// Shared encodings and helpers for the whack-a-mole mole generator.
package hamster_pop_ctrl_pkg;

    // Game FSM states driven into the mole controller.
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] POP  = 2'b01;
    localparam logic [1:0] HIT  = 2'b10;
    localparam logic [1:0] STOP = 2'b11;

    // Internal controller states.
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] GAP    = 2'b01;
    localparam logic [1:0] UP     = 2'b10;
    localparam logic [1:0] FREEZE = 2'b11;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fold the low LFSR nibble onto 0..9 and avoid repeating the last hole.
    function automatic logic [3:0] pick_hole(input logic [7:0] l, input logic [3:0] last);
        logic [3:0] h;
        h = (l[3:0] >= 4'd10) ? (l[3:0] - 4'd10) : l[3:0];
        if (h == last) begin
            h = (h == 4'd9) ? 4'd0 : (h + 4'd1);
        end
        return h;
    endfunction

    function automatic logic [9:0] hole_onehot(input logic [3:0] h);
        return 10'd1 << h;
    endfunction

    // Two-digit BCD increment {tens, ones}, saturating at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] s);
        logic [7:0] r;
        if (s == 8'h99) begin
            r = s;
        end else if (s[3:0] == 4'd9) begin
            r = {s[7:4] + 4'd1, 4'd0};
        end else begin
            r = {s[7:4], s[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/hamster_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used for hole selection.
module hamster_lfsr
    import hamster_pop_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Shift left with feedback into bit 0; never reaches zero from the seed.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Advance every clock, reload the non-zero seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/hamster_pop_ctrl.sv
// Mole generator and hit detector: pops moles at pseudo-random holes, times
// each pop and keeps a saturating two-digit BCD score.
module hamster_pop_ctrl
    import hamster_pop_ctrl_pkg::*;
#(
    parameter int unsigned MOLE_TICKS = 150,
    parameter int unsigned GAP_TICKS  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic       tick_100,
    input  logic [9:0] hit_btn,
    output logic [9:0] hamster_op,
    output logic       led_test_op,
    output logic [3:0] score1,
    output logic [3:0] score0
);

    localparam int unsigned MAX_TICKS = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
    localparam int unsigned CNT_W     = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0] MOLE_LAST = CNT_W'(MOLE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

    logic [7:0]       lfsr;
    logic [1:0]       fsm_q,   fsm_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       hole_q,  hole_d;
    logic [9:0]       ham_q,   ham_d;
    logic             led_q,   led_d;
    logic [7:0]       score_q, score_d;
    logic [3:0]       new_hole;
    logic             hit_ok;

    hamster_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .lfsr_o (lfsr)
    );

    // Only the press on the lit hole counts; other bits are ignored.
    assign hit_ok   = |(hit_btn & ham_q);
    assign new_hole = pick_hole(lfsr, hole_q);

    // Next-state logic: HOLD beats STOP beats everything the pop FSM does.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        hole_d  = hole_q;
        ham_d   = ham_q;
        score_d = score_q;
        led_d   = 1'b0;
        if (state == HOLD) begin
            fsm_d   = IDLE;
            score_d = '0;
            ham_d   = '0;
            cnt_d   = '0;
        end else if (state == STOP) begin
            fsm_d = FREEZE;
            ham_d = '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (state == POP || state == HIT) begin
                        fsm_d = GAP;
                        cnt_d = '0;
                    end
                end
                GAP: begin
                    if (tick_100) begin
                        if (cnt_q == GAP_LAST) begin
                            hole_d = new_hole;
                            ham_d  = hole_onehot(new_hole);
                            cnt_d  = '0;
                            fsm_d  = UP;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                UP: begin
                    if (hit_ok) begin
                        led_d   = 1'b1;
                        score_d = bcd_inc_sat(score_q);
                        ham_d   = '0;
                        cnt_d   = '0;
                        fsm_d   = GAP;
                    end else if (tick_100) begin
                        if (cnt_q == MOLE_LAST) begin
                            ham_d = '0;
                            cnt_d = '0;
                            fsm_d = GAP;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                FREEZE: begin
                    fsm_d = FREEZE;
                end
                default: begin
                    fsm_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            hole_q  <= '0;
            ham_q   <= '0;
            led_q   <= 1'b0;
            score_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            hole_q  <= hole_d;
            ham_q   <= ham_d;
            led_q   <= led_d;
            score_q <= score_d;
        end
    end

    assign hamster_op  = ham_q;
    assign led_test_op = led_q;
    assign score1      = score_q[7:4];
    assign score0      = score_q[3:0];

endmodule

// File: tb/tb_hamster_pop_ctrl.sv
// Self-checking bench for hamster_pop_ctrl using a scoreboard of expected
// {hamster_op, led_test_op, score} values pushed as stimulus is driven.
module tb_hamster_pop_ctrl;

    localparam int unsigned GAP_T  = 2;
    localparam int unsigned MOLE_T = 4;
    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_POP  = 2'b01;
    localparam logic [1:0] S_STOP = 2'b11;

    typedef struct {
        logic [9:0] ham;
        logic       led;
        logic [7:0] score;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    logic       tick_100;
    logic [9:0] hit_btn;
    logic [9:0] hamster_op;
    logic       led_test_op;
    logic [3:0] score1;
    logic [3:0] score0;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    logic [7:0] m_lfsr;
    logic [3:0] m_last;
    logic [7:0] m_score;

    hamster_pop_ctrl #(
        .MOLE_TICKS (MOLE_T),
        .GAP_TICKS  (GAP_T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .tick_100    (tick_100),
        .hit_btn     (hit_btn),
        .hamster_op  (hamster_op),
        .led_test_op (led_test_op),
        .score1      (score1),
        .score0      (score0)
    );

    always #5 clk = ~clk;

    // Reference LFSR, stepped on the same edges as the design.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [3:0] ref_pick(input logic [7:0] l, input logic [3:0] last);
        int n;
        n = int'(l[3:0]);
        if (n > 9) n = n - 10;
        if (n == int'(last)) n = (n + 1) % 10;
        return 4'(n);
    endfunction

    function automatic logic [7:0] ref_inc(input logic [7:0] s);
        int v;
        v = int'(s[7:4]) * 10 + int'(s[3:0]);
        if (v < 99) v = v + 1;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // From GAP with counter 0 and ticks running: mole must appear on the final tick.
    task automatic test_gap_to_mole();
        exp_t e;
        logic [3:0] h;
        tick_100 = 1'b1;
        hit_btn  = '0;
        for (int i = 0; i < int'(GAP_T); i++) begin
            if (i == int'(GAP_T) - 1) begin
                h = ref_pick(m_lfsr, m_last);
                m_last = h;
                sb.push_back('{ham: 10'd1 << h, led: 1'b0, score: m_score});
            end
            cyc();
            n_tests++;
            if (i == int'(GAP_T) - 1) begin
                e = sb.pop_front();
                if ({hamster_op, led_test_op, score1, score0} !== {e.ham, e.led, e.score}) begin
                    n_fail++;
                    $display("FAIL gap_mole: got ham=%b led=%b score=%h%h want ham=%b led=%b score=%h",
                             hamster_op, led_test_op, score1, score0, e.ham, e.led, e.score);
                end
                n_tests++;
                if ($countones(hamster_op) != 1) begin
                    n_fail++;
                    $display("FAIL mole_onehot: got ham=%b want exactly one bit in 0..9", hamster_op);
                end
            end else if (hamster_op !== 10'd0) begin
                n_fail++;
                $display("FAIL gap_dark: got ham=%b want 0", hamster_op);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; state = S_HOLD; tick_100 = 1'b0; hit_btn = '0;
        m_last = '0; m_score = '0;
        cyc(); cyc();
        rst = 1'b0;
        n_tests++;
        if ({hamster_op, led_test_op, score1, score0} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset: got ham=%b led=%b score=%h%h want all 0",
                     hamster_op, led_test_op, score1, score0);
        end
    endtask

    task automatic test_first_mole();
        state = S_POP; tick_100 = 1'b1;
        cyc();
        n_tests++;
        if (hamster_op !== 10'd0) begin
            n_fail++;
            $display("FAIL idle_to_gap: got ham=%b want 0", hamster_op);
        end
        test_gap_to_mole();
    endtask

    // Correct hit with ticks paused, then confirm the pulse lasted one cycle and relight.
    task automatic test_hit();
        exp_t e;
        tick_100 = 1'b0;
        hit_btn  = 10'd1 << m_last;
        m_score  = ref_inc(m_score);
        sb.push_back('{ham: 10'd0, led: 1'b1, score: m_score});
        cyc();
        hit_btn = '0;
        e = sb.pop_front();
        n_tests++;
        if ({hamster_op, led_test_op, score1, score0} !== {e.ham, e.led, e.score}) begin
            n_fail++;
            $display("FAIL hit: got ham=%b led=%b score=%h%h want ham=%b led=%b score=%h",
                     hamster_op, led_test_op, score1, score0, e.ham, e.led, e.score);
        end
        cyc();
        n_tests++;
        if (led_test_op !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_pulse_width: got led=%b want 0", led_test_op);
        end
        test_gap_to_mole();
    endtask

    // No hit (only wrong-hole presses): mole times out, no score, next hole differs.
    task automatic test_timeout();
        exp_t e;
        logic [3:0] prev;
        tick_100 = 1'b1;
        prev = m_last;
        for (int i = 0; i < int'(MOLE_T); i++) begin
            hit_btn = (i == 0) ? ~(10'd1 << m_last) : '0;
            if (i == int'(MOLE_T) - 1) sb.push_back('{ham: 10'd0, led: 1'b0, score: m_score});
            cyc();
            hit_btn = '0;
            n_tests++;
            if (i == int'(MOLE_T) - 1) begin
                e = sb.pop_front();
                if ({hamster_op, led_test_op, score1, score0} !== {e.ham, e.led, e.score}) begin
                    n_fail++;
                    $display("FAIL timeout: got ham=%b led=%b score=%h%h want ham=%b led=%b score=%h",
                             hamster_op, led_test_op, score1, score0, e.ham, e.led, e.score);
                end
            end else if ({hamster_op, led_test_op} !== {10'd1 << prev, 1'b0}) begin
                n_fail++;
                $display("FAIL mole_held: got ham=%b led=%b want ham=%b led=0",
                         hamster_op, led_test_op, 10'd1 << prev);
            end
        end
        test_gap_to_mole();
        n_tests++;
        if (hamster_op === (10'd1 << prev)) begin
            n_fail++;
            $display("FAIL repeat_hole: got ham=%b want different from %b", hamster_op, 10'd1 << prev);
        end
    endtask

    task automatic test_hit_timeout_same();
        exp_t e;
        tick_100 = 1'b1;
        hit_btn  = '0;
        for (int i = 0; i < int'(MOLE_T) - 1; i++) cyc();
        hit_btn = 10'd1 << m_last;
        m_score = ref_inc(m_score);
        sb.push_back('{ham: 10'd0, led: 1'b1, score: m_score});
        cyc();
        hit_btn = '0;
        tick_100 = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if ({hamster_op, led_test_op, score1, score0} !== {e.ham, e.led, e.score}) begin
            n_fail++;
            $display("FAIL hit_vs_timeout: got ham=%b led=%b score=%h%h want ham=%b led=%b score=%h",
                     hamster_op, led_test_op, score1, score0, e.ham, e.led, e.score);
        end
        cyc();
        test_gap_to_mole();
    endtask

    // STOP with a simultaneous hit: no pulse, no score; frozen even if POP returns.
    task automatic test_stop();
        exp_t e;
        state = S_STOP; tick_100 = 1'b1;
        hit_btn = 10'd1 << m_last;
        sb.push_back('{ham: 10'd0, led: 1'b0, score: m_score});
        cyc();
        e = sb.pop_front();
        n_tests++;
        if ({hamster_op, led_test_op, score1, score0} !== {e.ham, e.led, e.score}) begin
            n_fail++;
            $display("FAIL stop_vs_hit: got ham=%b led=%b score=%h%h want ham=%b led=%b score=%h",
                     hamster_op, led_test_op, score1, score0, e.ham, e.led, e.score);
        end
        for (int i = 0; i < 6; i++) begin
            hit_btn = 10'h3FF;
            state   = (i < 2) ? S_STOP : S_POP;
            cyc();
            n_tests++;
            if ({hamster_op, led_test_op, score1, score0} !== {10'd0, 1'b0, m_score}) begin
                n_fail++;
                $display("FAIL freeze: got ham=%b led=%b score=%h%h want ham=0 led=0 score=%h",
                         hamster_op, led_test_op, score1, score0, m_score);
            end
        end
        hit_btn = '0;
    endtask

    task automatic test_hold();
        exp_t e;
        state = S_HOLD; tick_100 = 1'b1;
        m_score = '0;
        sb.push_back('{ham: 10'd0, led: 1'b0, score: 8'h00});
        cyc();
        e = sb.pop_front();
        n_tests++;
        if ({hamster_op, led_test_op, score1, score0} !== {e.ham, e.led, e.score}) begin
            n_fail++;
            $display("FAIL hold: got ham=%b led=%b score=%h%h want ham=%b led=%b score=%h",
                     hamster_op, led_test_op, score1, score0, e.ham, e.led, e.score);
        end
        state = S_POP;
        cyc();
        test_gap_to_mole();
    endtask

    // Hit repeatedly from 00: check the 09->10 carry and saturation at 99.
    task automatic test_score_wrap();
        for (int k = 0; k < 100; k++) begin
            test_hit();
            if (k == 9) begin
                n_tests++;
                if ({score1, score0} !== 8'h10) begin
                    n_fail++;
                    $display("FAIL bcd_carry: got score=%h%h want 10", score1, score0);
                end
            end
        end
        n_tests++;
        if ({score1, score0} !== 8'h99) begin
            n_fail++;
            $display("FAIL score_sat: got score=%h%h want 99", score1, score0);
        end
    endtask

    task automatic test_reset_mid_pop();
        exp_t e;
        rst = 1'b1; hit_btn = 10'd1 << m_last; tick_100 = 1'b1;
        sb.push_back('{ham: 10'd0, led: 1'b0, score: 8'h00});
        cyc();
        rst = 1'b0; hit_btn = '0; state = S_POP;
        m_last = '0; m_score = '0;
        e = sb.pop_front();
        n_tests++;
        if ({hamster_op, led_test_op, score1, score0} !== {e.ham, e.led, e.score}) begin
            n_fail++;
            $display("FAIL reset_mid_pop: got ham=%b led=%b score=%h%h want ham=%b led=%b score=%h",
                     hamster_op, led_test_op, score1, score0, e.ham, e.led, e.score);
        end
        cyc();
        test_gap_to_mole();
        test_gap_to_mole_after_timeout();
    endtask

    // Second mole after reset confirms the LFSR sequence restarted from the seed.
    task automatic test_gap_to_mole_after_timeout();
        tick_100 = 1'b1;
        for (int i = 0; i < int'(MOLE_T); i++) cyc();
        test_gap_to_mole();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; state = S_HOLD; tick_100 = 1'b0; hit_btn = '0;
        test_reset();
        test_first_mole();
        test_hit();
        test_timeout();
        test_hit_timeout_same();
        test_stop();
        test_hold();
        test_score_wrap();
        test_reset_mid_pop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
